// File: rtl/seq_key_pkg.sv
// Shared definitions for the sequential key checker: FSM state encoding
// and a helper that sizes counters from the largest value they must hold.
package seq_key_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        COMPARE = 2'd1,
        LOCKOUT = 2'd2
    } state_e;

    // Number of bits needed to represent 0..max_val (never less than one bit)
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_key_checker_if.sv
// Bundle of the key checker's button/key inputs and status outputs.
// The master side drives buttons and key; the slave side is the checker.
interface seq_key_checker_if
    import seq_key_pkg::*;
#(
    parameter int NUM_BTNS  = 3,
    parameter int SEQ_LEN   = 4,
    parameter int IDX_W     = 2,
    parameter int MAX_FAILS = 3
);

    localparam int ENTRY_W = width_for(SEQ_LEN);
    localparam int FAIL_W  = width_for(MAX_FAILS);

    logic [NUM_BTNS-1:0]      btn;
    logic [SEQ_LEN*IDX_W-1:0] key;
    logic                     success;
    logic                     fail;
    logic                     in_compare;
    logic                     locked;
    logic [ENTRY_W-1:0]       entry_cnt;
    logic [FAIL_W-1:0]        fail_cnt;

    modport master (
        output btn, key,
        input  success, fail, in_compare, locked, entry_cnt, fail_cnt
    );

    modport slave (
        input  btn, key,
        output success, fail, in_compare, locked, entry_cnt, fail_cnt
    );

endinterface

// File: rtl/btn_edge_encoder.sv
// Turns debounced buttons into single-cycle digit presses. A press is a
// rising edge on exactly one button; simultaneous edges are discarded.
module btn_edge_encoder #(
    parameter int NUM_BTNS = 3,
    parameter int IDX_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn,
    output logic                press_valid,
    output logic [IDX_W-1:0]    press_idx
);

    logic [NUM_BTNS-1:0] btn_prev_q, btn_prev_d;
    logic [NUM_BTNS-1:0] rise;
    logic                press_valid_q, press_valid_d;
    logic [IDX_W-1:0]    press_idx_q, press_idx_d;

    // Find new rising edges and encode the single active one as a digit
    always_comb begin
        btn_prev_d    = btn;
        rise          = btn & ~btn_prev_q;
        press_valid_d = $onehot(rise);
        press_idx_d   = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (rise[i]) begin
                press_idx_d = IDX_W'(i);
            end
        end
    end

    // History tracks the live buttons during reset so held keys are not presses
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q    <= btn;
            press_valid_q <= 1'b0;
            press_idx_q   <= '0;
        end else begin
            btn_prev_q    <= btn_prev_d;
            press_valid_q <= press_valid_d;
            press_idx_q   <= press_idx_d;
        end
    end

    assign press_valid = press_valid_q;
    assign press_idx   = press_idx_q;

endmodule

// File: rtl/seq_key_checker.sv
// Collects SEQ_LEN button digits, compares them one digit per CMP_CYCLES
// window against a key latched at compare start, and locks out after
// MAX_FAILS consecutive failures.
module seq_key_checker
    import seq_key_pkg::*;
#(
    parameter int NUM_BTNS       = 3,
    parameter int SEQ_LEN        = 4,
    parameter int IDX_W          = 2,
    parameter int CMP_CYCLES     = 16,
    parameter int CONST_TIME     = 0,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    seq_key_checker_if.slave bus
);

    localparam int ENTRY_W = width_for(SEQ_LEN);
    localparam int FAIL_W  = width_for(MAX_FAILS);
    localparam int CYC_W   = width_for(CMP_CYCLES - 1);
    localparam int DIG_W   = width_for(SEQ_LEN - 1);
    localparam int LOCK_W  = width_for(LOCKOUT_CYCLES - 1);
    localparam int KEY_W   = SEQ_LEN * IDX_W;

    localparam logic [ENTRY_W-1:0] ENTRY_LAST = ENTRY_W'(SEQ_LEN - 1);
    localparam logic [ENTRY_W-1:0] ENTRY_FULL = ENTRY_W'(SEQ_LEN);
    localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(CMP_CYCLES - 1);
    localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(SEQ_LEN - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);

    logic             press_valid;
    logic [IDX_W-1:0] press_idx;

    btn_edge_encoder #(
        .NUM_BTNS (NUM_BTNS),
        .IDX_W    (IDX_W)
    ) u_encoder (
        .clk         (clk),
        .rst         (rst),
        .btn         (bus.btn),
        .press_valid (press_valid),
        .press_idx   (press_idx)
    );

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   digits_q, digits_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [DIG_W-1:0]   digit_idx_q, digit_idx_d;
    logic               mism_q, mism_d;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [ENTRY_W-1:0] entry_cnt_q, entry_cnt_d;
    logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic               success_q, success_d;
    logic               fail_q, fail_d;
    logic               in_compare_q, in_compare_d;
    logic               locked_q, locked_d;

    logic               digit_bad;
    logic               mism_now;
    logic               compare_done;

    // Next-state logic: digit capture, windowed compare, verdict and lockout timing
    always_comb begin
        state_d      = state_q;
        digits_d     = digits_q;
        key_d        = key_q;
        cyc_d        = cyc_q;
        digit_idx_d  = digit_idx_q;
        mism_d       = mism_q;
        lock_cnt_d   = lock_cnt_q;
        entry_cnt_d  = entry_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        success_d    = success_q;
        fail_d       = fail_q;
        in_compare_d = in_compare_q;
        locked_d     = locked_q;
        digit_bad    = digits_q[int'(digit_idx_q)*IDX_W +: IDX_W] !=
                       key_q[int'(digit_idx_q)*IDX_W +: IDX_W];
        mism_now     = mism_q | digit_bad;
        compare_done = 1'b0;

        case (state_q)
            ENTRY: begin
                if (press_valid) begin
                    digits_d[int'(entry_cnt_q)*IDX_W +: IDX_W] = press_idx;
                    if (entry_cnt_q == '0) begin
                        success_d = 1'b0;
                        fail_d    = 1'b0;
                    end
                    if (entry_cnt_q == ENTRY_LAST) begin
                        entry_cnt_d  = ENTRY_FULL;
                        state_d      = COMPARE;
                        in_compare_d = 1'b1;
                        key_d        = bus.key;
                        cyc_d        = '0;
                        digit_idx_d  = '0;
                        mism_d       = 1'b0;
                    end else begin
                        entry_cnt_d = entry_cnt_q + ENTRY_W'(1);
                    end
                end
            end

            COMPARE: begin
                if (cyc_q != CYC_LAST) begin
                    cyc_d = cyc_q + CYC_W'(1);
                end else begin
                    cyc_d = '0;
                    if (digit_idx_q == DIG_LAST || (CONST_TIME == 0 && digit_bad)) begin
                        compare_done = 1'b1;
                    end else begin
                        digit_idx_d = digit_idx_q + DIG_W'(1);
                        mism_d      = mism_now;
                    end
                end

                if (compare_done) begin
                    in_compare_d = 1'b0;
                    entry_cnt_d  = '0;
                    state_d      = ENTRY;
                    if (!mism_now) begin
                        success_d  = 1'b1;
                        fail_d     = 1'b0;
                        fail_cnt_d = '0;
                    end else begin
                        success_d  = 1'b0;
                        fail_d     = 1'b1;
                        fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                        if (fail_cnt_q == FAIL_LAST) begin
                            state_d    = LOCKOUT;
                            locked_d   = 1'b1;
                            lock_cnt_d = '0;
                        end
                    end
                end
            end

            LOCKOUT: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ENTRY;
                    locked_d   = 1'b0;
                    fail_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end

            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    // FSM register bank with registered outputs; reset aborts any compare or lockout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ENTRY;
            digits_q     <= '0;
            key_q        <= '0;
            cyc_q        <= '0;
            digit_idx_q  <= '0;
            mism_q       <= 1'b0;
            lock_cnt_q   <= '0;
            entry_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            success_q    <= 1'b0;
            fail_q       <= 1'b0;
            in_compare_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            digits_q     <= digits_d;
            key_q        <= key_d;
            cyc_q        <= cyc_d;
            digit_idx_q  <= digit_idx_d;
            mism_q       <= mism_d;
            lock_cnt_q   <= lock_cnt_d;
            entry_cnt_q  <= entry_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            success_q    <= success_d;
            fail_q       <= fail_d;
            in_compare_q <= in_compare_d;
            locked_q     <= locked_d;
        end
    end

    assign bus.success    = success_q;
    assign bus.fail       = fail_q;
    assign bus.in_compare = in_compare_q;
    assign bus.locked     = locked_q;
    assign bus.entry_cnt  = entry_cnt_q;
    assign bus.fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_seq_key_checker.sv
// Scoreboard bench for seq_key_checker: the same button/key stimulus drives
// an early-exit and a constant-time instance; expected results are queued
// at entry time and popped by per-instance monitors when compare ends.
module tb_seq_key_checker;
    import seq_key_pkg::*;

    localparam int NUM_BTNS       = 3;
    localparam int SEQ_LEN        = 4;
    localparam int IDX_W          = 2;
    localparam int CMP_CYCLES     = 16;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 1024;
    localparam int WAIT_BOUND     = 3000;

    typedef struct {
        int len;
        bit success;
        int fail_cnt;
        bit lockout;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_BTNS-1:0]      btn;
    logic [SEQ_LEN*IDX_W-1:0] key;

    int   vectors     = 0;
    int   miscompares = 0;
    int   issued      = 0;
    int   model_fails = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    generate
        for (genvar g = 0; g < 2; g++) begin : gen_dut
            seq_key_checker_if #(
                .NUM_BTNS  (NUM_BTNS),
                .SEQ_LEN   (SEQ_LEN),
                .IDX_W     (IDX_W),
                .MAX_FAILS (MAX_FAILS)
            ) bus ();

            assign bus.btn = btn;
            assign bus.key = key;

            seq_key_checker #(
                .NUM_BTNS       (NUM_BTNS),
                .SEQ_LEN        (SEQ_LEN),
                .IDX_W          (IDX_W),
                .CMP_CYCLES     (CMP_CYCLES),
                .CONST_TIME     (g),
                .MAX_FAILS      (MAX_FAILS),
                .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
            ) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );

            int   ic_len   = 0;
            int   lock_len = 0;
            int   done_cnt = 0;
            int   have;
            bit   in_lock  = 1'b0;
            exp_t e;

            // Monitor: measure compare/lockout lengths and score each verdict
            always @(negedge clk) begin
                checkOutput($sformatf("ct%0d success_fail_exclusive", g),
                            int'(bus.success & bus.fail), 0);
                checkOutput($sformatf("ct%0d compare_locked_exclusive", g),
                            int'(bus.in_compare & bus.locked), 0);
                if (rst) begin
                    ic_len   = 0;
                    lock_len = 0;
                    in_lock  = 1'b0;
                    if (g == 0) exp_q0.delete();
                    else        exp_q1.delete();
                end else if (in_lock) begin
                    if (bus.locked) begin
                        lock_len++;
                    end else begin
                        checkOutput($sformatf("ct%0d lockout_len", g), lock_len, LOCKOUT_CYCLES);
                        checkOutput($sformatf("ct%0d fail_cnt_after_lock", g), int'(bus.fail_cnt), 0);
                        checkOutput($sformatf("ct%0d fail_held_after_lock", g), int'(bus.fail), 1);
                        checkOutput($sformatf("ct%0d entry_cnt_after_lock", g), int'(bus.entry_cnt), 0);
                        in_lock = 1'b0;
                        done_cnt++;
                    end
                end else if (bus.in_compare) begin
                    ic_len++;
                end else if (ic_len > 0) begin
                    have = (g == 0) ? exp_q0.size() : exp_q1.size();
                    checkOutput($sformatf("ct%0d result_expected", g), int'(have > 0), 1);
                    if (have > 0) begin
                        if (g == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        checkOutput($sformatf("ct%0d compare_len", g), ic_len, e.len);
                        checkOutput($sformatf("ct%0d success", g), int'(bus.success), int'(e.success));
                        checkOutput($sformatf("ct%0d fail", g), int'(bus.fail), int'(!e.success));
                        checkOutput($sformatf("ct%0d fail_cnt", g), int'(bus.fail_cnt), e.fail_cnt);
                        checkOutput($sformatf("ct%0d locked", g), int'(bus.locked), int'(e.lockout));
                        checkOutput($sformatf("ct%0d entry_cnt_cleared", g), int'(bus.entry_cnt), 0);
                        if (e.lockout) begin
                            in_lock  = 1'b1;
                            lock_len = int'(bus.locked);
                        end else begin
                            done_cnt++;
                        end
                    end
                    ic_len = 0;
                end
            end
        end
    endgenerate

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pressDigit(input int d);
        btn = NUM_BTNS'(1 << d);
        tick($urandom_range(1, 3));
        btn = '0;
        tick($urandom_range(1, 3));
    endtask

    function automatic logic [SEQ_LEN*IDX_W-1:0] randKey();
        logic [SEQ_LEN*IDX_W-1:0] k;
        k = '0;
        for (int d = 0; d < SEQ_LEN; d++) begin
            k[d*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, NUM_BTNS - 1));
        end
        return k;
    endfunction

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (!(gen_dut[0].done_cnt >= issued && gen_dut[1].done_cnt >= issued) && n < WAIT_BOUND) begin
            tick();
            n++;
        end
        checkOutput($sformatf("%s result_timeout", tag), int'(n >= WAIT_BOUND), 0);
    endtask

    // Issue one entry: derive the expected verdict from the key, queue it, press the digits
    task automatic applyStimulus(input logic [SEQ_LEN*IDX_W-1:0] entry, input bit key_toggle,
                                 input bit double_edge, input bit lock_presses);
        int   first_bad;
        exp_t e0;
        exp_t e1;
        first_bad = -1;
        for (int d = SEQ_LEN - 1; d >= 0; d--) begin
            if (entry[d*IDX_W +: IDX_W] != key[d*IDX_W +: IDX_W]) first_bad = d;
        end
        e0.success = (first_bad < 0);
        if (e0.success) begin
            model_fails = 0;
        end else begin
            model_fails++;
        end
        e0.fail_cnt = model_fails;
        e0.lockout  = (model_fails == MAX_FAILS);
        if (e0.lockout) model_fails = 0;
        e1     = e0;
        e0.len = e0.success ? SEQ_LEN * CMP_CYCLES : (first_bad + 1) * CMP_CYCLES;
        e1.len = SEQ_LEN * CMP_CYCLES;
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
        issued++;

        for (int d = 0; d < SEQ_LEN; d++) begin
            if (double_edge && d == 1) begin
                btn = NUM_BTNS'(3);
                tick(2);
                btn = '0;
                tick(2);
            end
            pressDigit(int'(entry[d*IDX_W +: IDX_W]));
        end
        if (key_toggle) begin
            tick(6);
            key = randKey();
        end
        if (lock_presses && e0.lockout) begin
            tick(200);
            pressDigit(0);
            pressDigit(1);
        end
        waitDone("entry");
        tick(2);
    endtask

    task automatic checkIdle(input string tag);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("%s ct%0d success", tag, g),
                        int'(g == 0 ? gen_dut[0].bus.success : gen_dut[1].bus.success), 0);
            checkOutput($sformatf("%s ct%0d fail", tag, g),
                        int'(g == 0 ? gen_dut[0].bus.fail : gen_dut[1].bus.fail), 0);
            checkOutput($sformatf("%s ct%0d in_compare", tag, g),
                        int'(g == 0 ? gen_dut[0].bus.in_compare : gen_dut[1].bus.in_compare), 0);
            checkOutput($sformatf("%s ct%0d locked", tag, g),
                        int'(g == 0 ? gen_dut[0].bus.locked : gen_dut[1].bus.locked), 0);
            checkOutput($sformatf("%s ct%0d entry_cnt", tag, g),
                        int'(g == 0 ? gen_dut[0].bus.entry_cnt : gen_dut[1].bus.entry_cnt), 0);
            checkOutput($sformatf("%s ct%0d fail_cnt", tag, g),
                        int'(g == 0 ? gen_dut[0].bus.fail_cnt : gen_dut[1].bus.fail_cnt), 0);
        end
    endtask

    // Stimulus: directed entries, a randomized run, then reset corner cases
    initial begin
        logic [SEQ_LEN*IDX_W-1:0] entry;
        int                       pos;
        int                       old_digit;

        btn = '0;
        key = 8'h24;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        checkIdle("reset");

        applyStimulus(8'h24, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h25, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h64, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h24, 1'b1, 1'b0, 1'b0);

        key = 8'h24;
        applyStimulus(8'h25, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h64, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h20, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h24, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            entry = key;
            if ($urandom_range(0, 1) == 0) begin
                pos       = $urandom_range(0, SEQ_LEN - 1);
                old_digit = int'(entry[pos*IDX_W +: IDX_W]);
                entry[pos*IDX_W +: IDX_W] = IDX_W'((old_digit + $urandom_range(1, NUM_BTNS - 1)) % NUM_BTNS);
            end
            applyStimulus(entry, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b1);
        end

        for (int d = 0; d < SEQ_LEN; d++) begin
            pressDigit(int'(key[d*IDX_W +: IDX_W]));
        end
        tick(10);
        checkOutput("mid_compare ct0 in_compare", int'(gen_dut[0].bus.in_compare), 1);
        checkOutput("mid_compare ct1 in_compare", int'(gen_dut[1].bus.in_compare), 1);
        rst = 1'b1;
        tick();
        checkIdle("reset_mid_compare");
        rst = 1'b0;
        model_fails = 0;
        tick(2);

        btn = NUM_BTNS'(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        btn = '0;
        tick(2);
        checkOutput("held_btn ct0 entry_cnt", int'(gen_dut[0].bus.entry_cnt), 0);
        checkOutput("held_btn ct1 entry_cnt", int'(gen_dut[1].bus.entry_cnt), 0);

        applyStimulus(key, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
